// File: rtl/prog_loader.sv
// Program loader / run controller: streams words into instruction memory, then runs the core for a cycle budget.
// Optional checksum verification of the loaded image is enabled with PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int INST_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int CYC_W    = 16,
    parameter int RST_HOLD = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_words,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
`ifdef PROG_LOADER_CHECKSUM_EN
    input  logic [INST_W-1:0] expected_sum,
    output logic [INST_W-1:0] checksum,
    output logic              sum_err,
`endif
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W:0]   word_count
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_STOP} state_t;

    state_t              state_reg,   state_next;
    logic [ADDR_W:0]     n_reg,       n_next;
    logic [CYC_W-1:0]    budget_reg,  budget_next;
    logic [ADDR_W:0]     wc_reg,      wc_next;
    logic [HOLD_W-1:0]   settle_reg,  settle_next;
    logic [CYC_W-1:0]    run_cnt_reg, run_cnt_next;
    logic                we_reg,      we_next;
    logic [ADDR_W-1:0]   addr_reg,    addr_next;
    logic [INST_W-1:0]   wdata_reg,   wdata_next;
    logic                timeout_reg, timeout_next;
    logic [ADDR_W:0]     wc_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INST_W-1:0]   sum_reg,     sum_next;
    logic [INST_W-1:0]   exp_reg,     exp_next;
    logic                serr_reg,    serr_next;
    logic [INST_W-1:0]   sum_inc;

    assign sum_inc = sum_reg + in_data;
`endif

    assign wc_inc = wc_reg + 1'b1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg   <= S_IDLE;
            n_reg       <= '0;
            budget_reg  <= '0;
            wc_reg      <= '0;
            settle_reg  <= '0;
            run_cnt_reg <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            timeout_reg <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_reg     <= '0;
            exp_reg     <= '0;
            serr_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            n_reg       <= n_next;
            budget_reg  <= budget_next;
            wc_reg      <= wc_next;
            settle_reg  <= settle_next;
            run_cnt_reg <= run_cnt_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            timeout_reg <= timeout_next;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_reg     <= sum_next;
            exp_reg     <= exp_next;
            serr_reg    <= serr_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        n_next       = n_reg;
        budget_next  = budget_reg;
        wc_next      = wc_reg;
        settle_next  = settle_reg;
        run_cnt_next = run_cnt_reg;
        we_next      = 1'b0;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        timeout_next = timeout_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_next     = sum_reg;
        exp_next     = exp_reg;
        serr_next    = serr_reg;
`endif
        case (state_reg)
            S_IDLE, S_STOP: begin
                if (start) begin
                    n_next       = (num_words > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_words;
                    budget_next  = run_cycles;
                    wc_next      = '0;
                    settle_next  = '0;
                    run_cnt_next = '0;
                    timeout_next = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_next     = '0;
                    exp_next     = expected_sum;
                    serr_next    = 1'b0;
`endif
                    state_next   = (num_words == '0) ? S_SETTLE : S_LOAD;
                end
            end
            S_LOAD: begin
                // An accept coinciding with abort is dropped entirely, including its write.
                if (abort) begin
                    state_next   = S_STOP;
                    timeout_next = 1'b0;
                end else if (in_valid) begin
                    we_next    = 1'b1;
                    addr_next  = wc_reg[ADDR_W-1:0];
                    wdata_next = in_data;
                    wc_next    = wc_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_next   = sum_inc;
`endif
                    if (wc_inc == n_reg) begin
                        settle_next = '0;
                        state_next  = S_SETTLE;
`ifdef PROG_LOADER_CHECKSUM_EN
                        if (sum_inc != exp_reg) begin
                            serr_next  = 1'b1;
                            state_next = S_STOP;
                        end
`endif
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_next   = S_STOP;
                    timeout_next = 1'b0;
                end else if (settle_reg == HOLD_W'(RST_HOLD - 1)) begin
                    run_cnt_next = '0;
                    state_next   = S_RUN;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next   = S_STOP;
                    timeout_next = 1'b0;
                end else if ((budget_reg != '0) && (run_cnt_reg == budget_reg - CYC_W'(1))) begin
                    state_next   = S_STOP;
                    timeout_next = 1'b1;
                end else begin
                    run_cnt_next = run_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign in_ready   = (state_reg == S_LOAD);
    assign core_reset = (state_reg != S_RUN);
    assign running    = (state_reg == S_RUN);
    assign done       = (state_reg == S_STOP);
    assign timeout    = timeout_reg;
    assign word_count = wc_reg;
    assign mem_we     = we_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign checksum   = sum_reg;
    assign sum_err    = serr_reg;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: timeline model compared every cycle plus literal scenario checks.
// Checksum scenarios are built only when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

    localparam int INST_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int CYC_W    = 16;
    localparam int RST_HOLD = 2;
    localparam int DEPTH    = 16;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W:0]   num_words = '0;
    logic [CYC_W-1:0]  run_cycles = '0;
    logic              in_valid = 1'b0;
    logic [INST_W-1:0] in_data = '0;
    logic              in_ready, mem_we, core_reset, running, done, timeout;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_wdata;
    logic [ADDR_W:0]   word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INST_W-1:0] expected_sum = '0;
    logic [INST_W-1:0] checksum;
    logic              sum_err;
`endif

    prog_loader #(.INST_W(INST_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W), .RST_HOLD(RST_HOLD)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
        .num_words(num_words), .run_cycles(run_cycles),
        .in_valid(in_valid), .in_data(in_data),
`ifdef PROG_LOADER_CHECKSUM_EN
        .expected_sum(expected_sum), .checksum(checksum), .sum_err(sum_err),
`endif
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset(core_reset), .running(running), .done(done), .timeout(timeout),
        .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a load ends at some cycle, the core is released RST_HOLD cycles later
    // and stops `budget` cycles after release.
    bit      m_active, m_loading, m_stopped, m_timeout, m_we;
    int      m_n, m_wc, m_budget, m_addr;
    longint  m_cyc, m_release;
    logic [INST_W-1:0] m_wdata;
    logic [INST_W-1:0] m_sum, m_exp;
    bit      m_sum_err;

    initial begin
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) begin
                m_active = 0; m_loading = 0; m_stopped = 0; m_timeout = 0; m_we = 0;
                m_n = 0; m_wc = 0; m_budget = 0; m_addr = 0; m_cyc = 0; m_release = 0;
                m_wdata = '0; m_sum = '0; m_exp = '0; m_sum_err = 0;
            end else begin
                m_cyc++;
                m_we = 0;
                if (m_active && abort) begin
                    m_active = 0; m_loading = 0; m_stopped = 1; m_timeout = 0;
                end else if (m_active && !m_loading && m_budget != 0 && m_cyc == m_release + m_budget) begin
                    m_active = 0; m_stopped = 1; m_timeout = 1;
                end else if (!m_active && start) begin
                    m_active = 1; m_stopped = 0; m_timeout = 0; m_wc = 0; m_sum_err = 0;
                    m_budget = int'(run_cycles);
                    m_n = (int'(num_words) > DEPTH) ? DEPTH : int'(num_words);
                    m_sum = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    m_exp = expected_sum;
`endif
                    if (m_n == 0) begin
                        m_loading = 0;
                        m_release = m_cyc + RST_HOLD;
                    end else begin
                        m_loading = 1;
                    end
                end else if (m_loading && in_valid) begin
                    m_we = 1; m_addr = m_wc; m_wdata = in_data;
                    m_wc++;
                    m_sum = m_sum + in_data;
                    if (m_wc == m_n) begin
                        m_loading = 0;
                        m_release = m_cyc + RST_HOLD;
`ifdef PROG_LOADER_CHECKSUM_EN
                        if (m_sum != m_exp) begin
                            m_active = 0; m_stopped = 1; m_sum_err = 1;
                        end
`endif
                    end
                end
            end
        end
    end

    // Per-scenario statistics gathered from the DUT outputs.
    int tb_cyc = 0, writes = 0, run_cnt = 0, first_we_cyc = 0, last_we_cyc = 0, release_cyc = 0;
    logic [INST_W-1:0] shadow [0:DEPTH-1];

    initial begin
        forever begin
            bit exp_run;
            @(negedge CLK);
            tb_cyc++;
            exp_run = m_active && !m_loading && (m_cyc >= m_release);
            chk("in_ready",   32'(in_ready),   32'(m_loading));
            chk("mem_we",     32'(mem_we),     32'(m_we));
            if (m_we) begin
                chk("mem_addr",  32'(mem_addr),  32'(m_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            chk("core_reset", 32'(core_reset), 32'(!exp_run));
            chk("running",    32'(running),    32'(exp_run));
            chk("done",       32'(done),       32'(m_stopped));
            chk("timeout",    32'(timeout),    32'(m_timeout));
            chk("word_count", 32'(word_count), 32'(m_wc));
`ifdef PROG_LOADER_CHECKSUM_EN
            chk("checksum",   32'(checksum),   32'(m_sum));
            chk("sum_err",    32'(sum_err),    32'(m_sum_err));
`endif
            if (mem_we) begin
                if (writes == 0) first_we_cyc = tb_cyc;
                writes++;
                last_we_cyc = tb_cyc;
                shadow[mem_addr] = mem_wdata;
                $display("write addr=%0d data=%04h", mem_addr, mem_wdata);
            end
            if (running) begin
                if (run_cnt == 0) release_cyc = tb_cyc;
                run_cnt++;
            end
        end
    end

    logic [INST_W-1:0] words [0:19];

    task automatic clr_stats();
        writes = 0; run_cnt = 0; first_we_cyc = 0; last_we_cyc = 0; release_cyc = 0;
    endtask

    task automatic do_start(input int nw, input int rc);
        @(negedge CLK);
        clr_stats();
        num_words = (ADDR_W+1)'(nw);
        run_cycles = CYC_W'(rc);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        $display("start num_words=%0d run_cycles=%0d", nw, rc);
    endtask

    task automatic stream(input int n, input bit toggle, input int extra);
        int idx = 0;
        int k = 0;
        while (idx < n && k < 100) begin
            in_valid = toggle ? ~k[0] : 1'b1;
            in_data  = words[idx];
            #1;
            if (in_valid && in_ready) idx++;
            @(negedge CLK);
            k++;
        end
        chk("stream_accepts", 32'(idx), 32'(n));
        in_valid = 1'b0;
        chk("ready_after_last", 32'(in_ready), 32'd0);
        repeat (extra) begin
            in_valid = 1'b1;
            in_data  = 16'hBEEF;
            @(negedge CLK);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin
            @(negedge CLK);
            k++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // basic load + 25-cycle budget
        words[0] = 16'h98C3; words[1] = 16'h9906; words[2] = 16'h4063;
        do_start(3, 25);
        stream(3, 1'b0, 0);
        wait_done(100);
        chk("basic_writes",   32'(writes), 32'd3);
        chk("basic_consec",   32'(last_we_cyc - first_we_cyc), 32'd2);
        chk("basic_mem0",     32'(shadow[0]), 32'h98C3);
        chk("basic_mem1",     32'(shadow[1]), 32'h9906);
        chk("basic_mem2",     32'(shadow[2]), 32'h4063);
        chk("basic_wc",       32'(word_count), 32'd3);
        chk("basic_release",  32'(release_cyc - (last_we_cyc - 1)), 32'd3);
        chk("budget_run",     32'(run_cnt), 32'd25);
        chk("budget_timeout", 32'(timeout), 32'd1);
        chk("budget_corerst", 32'(core_reset), 32'd1);

        // backpressure, restart from STOP
        words[0] = 16'hA1A1; words[1] = 16'hB2B2;
        do_start(2, 4);
        chk("restart_cleared", 32'({done, timeout}), 32'd0);
        stream(2, 1'b1, 1);
        wait_done(50);
        chk("bp_writes", 32'(writes), 32'd2);
        chk("bp_mem0",   32'(shadow[0]), 32'hA1A1);
        chk("bp_mem1",   32'(shadow[1]), 32'hB2B2);
        chk("bp_mem2",   32'(shadow[2]), 32'h4063);
        chk("bp_wc",     32'(word_count), 32'd2);

        // clamp to DEPTH
        for (int i = 0; i < 20; i++) words[i] = 16'(16'h1000 + i * 16'h0101);
        do_start(20, 3);
        stream(16, 1'b0, 4);
        wait_done(50);
        chk("clamp_writes", 32'(writes), 32'd16);
        chk("clamp_wc",     32'(word_count), 32'd16);
        chk("clamp_mem0",   32'(shadow[0]), 32'h1000);
        chk("clamp_mem15",  32'(shadow[15]), 32'h1F0F);

        // empty load
        do_start(0, 5);
        wait_done(50);
        chk("empty_writes", 32'(writes), 32'd0);
        chk("empty_run",    32'(run_cnt), 32'd5);

        // abort on the second accept
        do_start(4, 10);
        in_valid = 1'b1; in_data = 16'hC001;
        @(negedge CLK);
        in_data = 16'hC002; abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        chk("abort_writes",  32'(writes), 32'd1);
        chk("abort_mem0",    32'(shadow[0]), 32'hC001);
        chk("abort_done",    32'(done), 32'd1);
        chk("abort_timeout", 32'(timeout), 32'd0);

        // unlimited run, abort in RUN
        do_start(0, 0);
        repeat (40) @(negedge CLK);
        chk("unlim_running", 32'(running), 32'd1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("runabort_done",    32'(done), 32'd1);
        chk("runabort_timeout", 32'(timeout), 32'd0);
        chk("runabort_running", 32'(running), 32'd0);

        // asynchronous reset during RUN
        do_start(0, 0);
        repeat (10) @(negedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("arst_core_reset", 32'(core_reset), 32'd1);
        chk("arst_running",    32'(running), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

`ifdef PROG_LOADER_CHECKSUM_EN
        words[0] = 16'h0001; words[1] = 16'hFFFF;
        expected_sum = 16'h0000;
        do_start(2, 3);
        stream(2, 1'b0, 0);
        wait_done(50);
        chk("cs_ok_err", 32'(sum_err), 32'd0);
        chk("cs_ok_run", 32'(run_cnt), 32'd3);
        expected_sum = 16'h0001;
        do_start(2, 3);
        stream(2, 1'b0, 0);
        wait_done(50);
        repeat (5) @(negedge CLK);
        chk("cs_bad_err",  32'(sum_err), 32'd1);
        chk("cs_bad_run",  32'(run_cnt), 32'd0);
        chk("cs_bad_crst", 32'(core_reset), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised program loader and run controller for the 16-bit teaching computer.
- Accepts an instruction stream over a valid/ready handshake and writes it into instruction memory through a write port, replacing hierarchical preload.
- Holds the core in reset during load and settle, releases it, then stops it after a programmable cycle budget or on abort.
- Sits between the bench or host stream source and the computer's instruction memory and reset input.

Parameters:
- INST_W, 16: instruction/data word width.
- ADDR_W, 4: instruction memory address width; DEPTH = 2**ADDR_W.
- CYC_W, 16: width of the run-cycle budget and run counter.
- RST_HOLD, 2: cycles core_reset stays asserted after the last word is written (minimum 1).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins load (honoured in IDLE and STOP only).
- abort  in  1  forces STOP from LOAD, SETTLE or RUN.
- num_words  in  ADDR_W+1  number of words to load.
- run_cycles  in  CYC_W  run budget in cycles; 0 = unlimited.
- in_valid  in  1  stream word valid.
- in_data  in  INST_W  stream word.
- in_ready  out  1  loader can accept a word.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  INST_W  write data.
- core_reset  out  1  active-high reset to the computer.
- running  out  1  core is executing.
- done  out  1  run finished (budget expiry or abort).
- timeout  out  1  run ended by budget expiry.
- word_count  out  ADDR_W+1  words accepted in the current load.

Behaviour:
- States: IDLE, LOAD, SETTLE, RUN, STOP.
- Reset values (RESET=0, asynchronous): state IDLE, core_reset 1, all other outputs 0, internal counters 0.
- IDLE:
  - in_ready 0, core_reset 1.
  - start with num_words>0: latch N = min(num_words, DEPTH), latch run_cycles, go to LOAD.
  - start with num_words==0: go directly to SETTLE.
- LOAD:
  - in_ready is 1 until the Nth word is accepted.
  - Accept occurs when in_valid && in_ready.
  - Write latency is 1 cycle: in the cycle after an accept, mem_we=1, mem_addr=word_count_before_accept[ADDR_W-1:0], mem_wdata=accepted word.
  - word_count increments on each accept.
  - On the Nth accept, in_ready is 0 from the next cycle and the state moves to SETTLE.
  - Excess input words are not accepted.
- SETTLE:
  - core_reset stays 1 for RST_HOLD cycles, counted from the first SETTLE cycle.
  - The final mem_we pulse lands in the first SETTLE cycle.
  - Then go to RUN.
- RUN:
  - core_reset 0 and running 1; the run counter increments every cycle from 0.
  - If run_cycles!=0 and counter==run_cycles-1: go to STOP with timeout=1.
  - run_cycles==0: run until abort.
- STOP:
  - core_reset 1, running 0, done 1; timeout holds its value.
  - start clears done, timeout and word_count and re-enters LOAD (or SETTLE when num_words==0).
  - Memory contents are not cleared.
- abort:
  - In LOAD, SETTLE or RUN: next state STOP, core_reset 1 the next cycle, timeout 0, done 1.
  - An accept in the same cycle as abort is dropped; its write is not issued.
- Priority: abort > budget expiry > handshake.
- start is ignored in LOAD, SETTLE and RUN.
- RESET asserted mid-load or mid-run: immediate return to reset values; any partially loaded memory is not rolled back.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[INST_W-1:0], the modulo-2**INST_W sum of accepted words, cleared on start.
  - Adds input expected_sum[INST_W-1:0], sampled at start.
  - Adds output sum_err[1].
  - At the end of LOAD, a mismatch sets sum_err=1 and goes to STOP with done=1 and core_reset held; the core never runs.
  - sum_err clears on start or reset.
- When not defined: no checksum ports or logic; LOAD always proceeds to SETTLE.

Test Plan:
- Basic load: num_words=3, stream 0x98C3, 0x9906, 0x4063 with in_valid held high -> mem_we pulses 3 consecutive cycles at addr 0,1,2 with those data; word_count=3; core_reset drops 1+RST_HOLD cycles after the last accept.
- Budget: run_cycles=25 -> running high exactly 25 cycles, then core_reset=1, done=1, timeout=1.
- Backpressure: in_valid toggling 1,0,1,0 with num_words=2 -> writes only on accepted cycles, addresses 0 then 1; in_ready 0 after the 2nd accept; a 3rd valid word is not accepted.
- Clamp and empty: num_words=20 with ADDR_W=4 -> exactly 16 writes, addr wraps never. num_words=0 -> no mem_we, straight to SETTLE and RUN.
- Abort and reset: abort on the 2nd accept cycle of a 4-word load -> only 1 write, done=1, timeout=0. RESET low during RUN -> core_reset=1 and running=0 asynchronously.
- Checksum (macro defined): words 0x0001, 0xFFFF with expected_sum=0x0000 -> sum_err=0 and run proceeds. expected_sum=0x0001 -> sum_err=1, STOP, core never released.
